// File: rtl/decode_pkg.sv
// Shared decode constants, ALU op encoding, FSM states and the funct3 mapping helper.
package decode_pkg;

   localparam int unsigned ILEN = 32;

   typedef logic [ILEN-1:0] instr_t;

   localparam logic [6:0] OPC_R   = 7'b0110011;
   localparam logic [6:0] OPC_I   = 7'b0010011;
   localparam logic [6:0] OPC_LUI = 7'b0110111;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SRA  = 4'd8,
      ALU_SRL  = 4'd9
   } alu_op_e;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd1,
      S_READ   = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4
   } state_e;

   // Source of the second ALU operand.
   typedef enum logic [1:0] {
      SRC_RS2   = 2'd0,
      SRC_IMM   = 2'd1,
      SRC_SHAMT = 2'd2,
      SRC_LUI   = 2'd3
   } bsel_e;

   // Operation selected by funct3 when funct7 is the base encoding.
   function automatic alu_op_e f3_to_op(input logic [2:0] f3);
      case (f3)
         F3_ADD_SUB: f3_to_op = ALU_ADD;
         F3_SLL:     f3_to_op = ALU_SLL;
         F3_SLT:     f3_to_op = ALU_SLT;
         F3_SLTU:    f3_to_op = ALU_SLTU;
         F3_XOR:     f3_to_op = ALU_XOR;
         F3_SRL_SRA: f3_to_op = ALU_SRL;
         F3_OR:      f3_to_op = ALU_OR;
         default:    f3_to_op = ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/decode_ctrl_if.sv
// Instruction offer/accept handshake between fetch and the decoder.
interface decode_ctrl_if;
   import decode_pkg::*;

   instr_t instr_data;
   logic   instr_valid;
   logic   instr_ready;

   modport master (output instr_data, output instr_valid, input instr_ready);
   modport slave  (input instr_data, input instr_valid, output instr_ready);
endinterface

// File: rtl/imm_gen.sv
// Immediate extraction: I-immediate, shift amount and LUI immediate.
module imm_gen #(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:12]     instr_hi,
   output logic [XLEN-1:0]  imm_i,
   output logic [XLEN-1:0]  shamt,
   output logic [XLEN-1:0]  imm_u
);

   logic signed [11:0] i12;
   logic signed [31:0] u32;

   // Signed temporaries so the width casts sign-extend.
   always_comb begin
      i12   = instr_hi[31:20];
      u32   = {instr_hi[31:12], 12'b0};
      imm_i = XLEN'(i12);
      shamt = XLEN'(instr_hi[24:20]);
      imm_u = XLEN'(u32);
   end

endmodule

// File: rtl/decode_ctrl.sv
// Multi-cycle RV32 integer decode/execute controller driving an external ALU and RF.
module decode_ctrl
   import decode_pkg::*;
#(
   parameter  int unsigned XLEN  = 32,
   parameter  int unsigned NREGS = 32,
   parameter  int unsigned CNT_W = 32,
   localparam int unsigned AW    = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   decode_ctrl_if.slave      instr_if,
   output logic [3:0]        alu_op,
   output logic [XLEN-1:0]   alu_a,
   output logic [XLEN-1:0]   alu_b,
   input  logic [XLEN-1:0]   alu_result,
   output logic              rf_ce,
   output logic              rf_we,
   output logic [AW-1:0]     rf_rs1_addr,
   output logic [AW-1:0]     rf_rs2_addr,
   input  logic [XLEN-1:0]   rf_rs1_data,
   input  logic [XLEN-1:0]   rf_rs2_data,
   output logic [AW-1:0]     rf_wr_addr,
   output logic [XLEN-1:0]   rf_wr_data,
   output logic              illegal,
   output logic [CNT_W-1:0]  cycle_count,
   output logic [CNT_W-1:0]  instr_count
);

   state_e          state, state_d;
   instr_t          instr_q;
   logic [AW-1:0]   rd_q;

   logic [6:0]      opcode, funct7;
   logic [2:0]      funct3;
   alu_op_e         dec_op;
   bsel_e           dec_bsel;
   logic            dec_illegal;

   logic [XLEN-1:0] imm_i, shamt, imm_u;
   logic [XLEN-1:0] op_a_d, op_b_d;

   assign opcode = instr_q[6:0];
   assign funct3 = instr_q[14:12];
   assign funct7 = instr_q[31:25];

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr_hi (instr_q[31:12]),
      .imm_i    (imm_i),
      .shamt    (shamt),
      .imm_u    (imm_u)
   );

   // Instruction classification from the latched word.
   always_comb begin
      dec_op      = ALU_ADD;
      dec_bsel    = SRC_RS2;
      dec_illegal = 1'b0;
      case (opcode)
         OPC_R: begin
            if (funct7 == F7_BASE) begin
               dec_op = f3_to_op(funct3);
            end else if (funct7 == F7_ALT) begin
               case (funct3)
                  F3_ADD_SUB: dec_op = ALU_SUB;
                  F3_SRL_SRA: dec_op = ALU_SRA;
                  default:    dec_illegal = 1'b1;
               endcase
            end else begin
               dec_illegal = 1'b1;
            end
         end
         OPC_I: begin
            dec_bsel = SRC_IMM;
            dec_op   = f3_to_op(funct3);
            case (funct3)
               F3_SLL: begin
                  dec_bsel    = SRC_SHAMT;
                  dec_illegal = (funct7 != F7_BASE);
               end
               F3_SRL_SRA: begin
                  dec_bsel = SRC_SHAMT;
                  if (funct7 == F7_ALT) begin
                     dec_op = ALU_SRA;
                  end else if (funct7 != F7_BASE) begin
                     dec_illegal = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         OPC_LUI: begin
            dec_bsel = SRC_LUI;
            dec_op   = ALU_ADD;
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   // Operand selection captured on READ exit.
   always_comb begin
      op_a_d = (dec_bsel == SRC_LUI) ? '0 : rf_rs1_data;
      case (dec_bsel)
         SRC_RS2:   op_b_d = rf_rs2_data;
         SRC_IMM:   op_b_d = imm_i;
         SRC_SHAMT: op_b_d = shamt;
         default:   op_b_d = imm_u;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:   if (instr_if.instr_valid) state_d = S_DECODE;
         S_DECODE: state_d = dec_illegal ? S_IDLE : S_READ;
         S_READ:   state_d = S_EXEC;
         S_EXEC:   state_d = S_WB;
         S_WB:     state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // State-decoded strobes.
   always_comb begin
      instr_if.instr_ready = 1'b0;
      rf_ce                = 1'b0;
      rf_we                = 1'b0;
      illegal              = 1'b0;
      case (state)
         S_IDLE:   instr_if.instr_ready = 1'b1;
         S_DECODE: illegal = dec_illegal;
         S_READ:   rf_ce = 1'b1;
         S_WB: begin
            rf_ce = 1'b1;
            rf_we = (rd_q != '0);
         end
         default: ;
      endcase
   end

   // Datapath registers and performance counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q     <= '0;
         rd_q        <= '0;
         rf_rs1_addr <= '0;
         rf_rs2_addr <= '0;
         alu_op      <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         rf_wr_addr  <= '0;
         rf_wr_data  <= '0;
         cycle_count <= '0;
         instr_count <= '0;
      end else begin
         cycle_count <= cycle_count + CNT_W'(1);
         case (state)
            S_IDLE: begin
               if (instr_if.instr_valid && instr_if.instr_ready) instr_q <= instr_if.instr_data;
            end
            S_DECODE: begin
               rf_rs1_addr <= AW'(instr_q[19:15]);
               rf_rs2_addr <= AW'(instr_q[24:20]);
               rd_q        <= AW'(instr_q[11:7]);
            end
            S_READ: begin
               alu_a  <= op_a_d;
               alu_b  <= op_b_d;
               alu_op <= dec_op;
            end
            S_EXEC: begin
               rf_wr_data <= alu_result;
               rf_wr_addr <= rd_q;
            end
            S_WB: instr_count <= instr_count + CNT_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: doc/decode_ctrl.md
DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 Parameter XLEN, default 32, datapath width of operands, immediates and write data.
REQ-002 Parameter NREGS, default 32, register-file depth; AW = $clog2(NREGS).
REQ-003 Parameter CNT_W, default 32, width of the performance counters.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 instr_data  in  32  RV32 instruction word; sampled only on the accept edge.
REQ-007 instr_valid  in  1  instruction offered.
REQ-008 instr_ready  out  1  decoder idle and able to accept.
REQ-009 alu_op  out  4  ALU operation: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SLT=6, SLTU=7, SRA=8, SRL=9.
REQ-010 alu_a, alu_b  out  XLEN  ALU operands.
REQ-011 alu_result  in  XLEN  combinational ALU result.
REQ-012 rf_ce  out  1  register-file chip enable.
REQ-013 rf_we  out  1  register-file write strobe.
REQ-014 rf_rs1_addr, rf_rs2_addr  out  AW  read addresses.
REQ-015 rf_rs1_data, rf_rs2_data  in  XLEN  combinational read data.
REQ-016 rf_wr_addr  out  AW  write address.
REQ-017 rf_wr_data  out  XLEN  write data.
REQ-018 illegal  out  1  one-cycle pulse for an unsupported encoding.
REQ-019 cycle_count, instr_count  out  CNT_W  free-running cycle counter and retired-instruction counter.

Function
REQ-020 The FSM SHALL have states IDLE, DECODE, READ, EXEC and WB; instr_ready SHALL be 1 only in IDLE.
REQ-021 Accept SHALL occur on an edge where instr_valid && instr_ready: latch instr_data, go IDLE->DECODE.
REQ-022 DECODE SHALL accept opcodes 0110011 (R), 0010011 (I-ALU) and 0110111 (LUI), and SHALL set rf_rs1_addr, rf_rs2_addr and rd from the instruction fields; next state READ.
REQ-023 These SHALL be illegal: any other opcode; R-type funct7 outside {0000000, 0100000}; 0100000 with funct3 other than 000 or 101; SLLI with funct7 != 0; SRLI/SRAI with funct7 outside {0000000, 0100000}. For an illegal encoding, illegal SHALL pulse during the DECODE cycle, the FSM SHALL return to IDLE, and there SHALL be no RF write and no instr_count increment.
REQ-024 The I-immediate SHALL be instr[31:20] sign-extended to XLEN; the shift amount SHALL be instr[24:20] zero-extended; the LUI immediate SHALL be {instr[31:12],12'b0} sign-extended to XLEN.
REQ-025 In READ, rf_ce=1 and rf_we=0; on exit, register alu_a = rs1 data (0 for LUI) and alu_b = rs2 data (R), the immediate (I, LUI) or the shift amount; register alu_op (LUI uses ADD); next state EXEC.
REQ-026 In EXEC, register rf_wr_data <= alu_result and rf_wr_addr <= rd; next state WB.
REQ-027 In WB, rf_ce=1, and rf_we=1 for exactly that cycle unless rd==0; instr_count SHALL increment, including when rd==0; next state IDLE.
REQ-028 Latency SHALL be: accept edge T, rf_we high during cycle T+4, instr_ready high again at T+5; throughput one instruction per 5 cycles.
REQ-029 cycle_count SHALL increment every non-reset cycle; both counters SHALL wrap modulo 2^CNT_W.
REQ-030 rf_ce SHALL be 0 in IDLE and DECODE; rf_we SHALL be 0 outside WB.

Reset
REQ-031 On rst: state = IDLE, instr_ready = 1, and all other outputs, counters and internal registers = 0.
REQ-032 Reset asserted in any state SHALL abort the instruction in flight, with no rf_we, no illegal pulse and no count.

Structure
REQ-033 Package decode_pkg SHALL hold the opcode constants, the funct3/funct7 constants, the alu_op encoding and the state enum.
REQ-034 Immediate extraction and sign extension SHALL live in one combinational sub-module, imm_gen, parametrised by XLEN.

Verification
REQ-035 Accept 0xFFF00293 (ADDI x5,x0,-1) -> alu_op=0, alu_b=0xFFFFFFFF, rf_we at T+4 with addr 5 and data 0xFFFFFFFF.
REQ-036 x1=10, x2=3, accept 0x402081B3 (SUB x3,x1,x2) -> alu_op=1, write of 7 to x3, instr_count +1.
REQ-037 Accept 0x123453B7 (LUI x7,0x12345) -> write of 0x12345000 to x7.
REQ-038 Accept 0x00000000 -> illegal high for one cycle at T+1, no rf_we, instr_count unchanged, instr_ready=1 at T+2.
REQ-039 Accept 0x00500013 (ADDI x0,x0,5) -> rf_we stays 0 and instr_count +1; with CNT_W=4, 16 retirements wrap instr_count to 0.
REQ-040 rst pulsed during EXEC -> no rf_we, all outputs 0, instr_ready=1 on the next cycle.
